// File: rtl/adder_scheduler_if.sv
// Request/result bundle between the lab control logic (master) and adder_scheduler (slave).
interface adder_scheduler_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned DW = 2 * WIDTH;

  logic          req0;
  logic          req1;
  logic          wide0;
  logic          wide1;
  logic          cin0;
  logic          cin1;
  logic [DW-1:0] a0;
  logic [DW-1:0] b0;
  logic [DW-1:0] a1;
  logic [DW-1:0] b1;

  logic          busy;
  logic          gnt;
  logic          done;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] sum;
  logic          co;

  modport master (
    output req0, req1, wide0, wide1, cin0, cin1, a0, b0, a1, b1,
    input  busy, gnt, done, ack0, ack1, sum, co
  );

  modport slave (
    input  req0, req1, wide0, wide1, cin0, cin1, a0, b0, a1, b1,
    output busy, gnt, done, ack0, ack1, sum, co
  );
endinterface

// File: rtl/adder_scheduler.sv
// Round-robin two-port scheduler for one shared WIDTH-bit ripple-carry adder built from 4-bit slices.
// Define ADDSCHED_CHAIN_EN to enable the chained two-pass 2*WIDTH-bit add (CALC_HI state).
module adder_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                resetn,
  adder_scheduler_if.slave    bus
);

  localparam int unsigned DW     = 2 * WIDTH;
  localparam int unsigned NSLICE = WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC_LO = 2'd1,
    DONE    = 2'd2
`ifdef ADDSCHED_CHAIN_EN
    ,
    CALC_HI = 2'd3
`endif
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               grant_c;
  logic               gsel_c;

  logic               last_q;
  logic [WIDTH-1:0]   a_lo_q;
  logic [WIDTH-1:0]   b_lo_q;
  logic               cin_q;
  logic               carry_q;
`ifdef ADDSCHED_CHAIN_EN
  logic [WIDTH-1:0]   a_hi_q;
  logic [WIDTH-1:0]   b_hi_q;
  logic               wide_q;
`endif

  logic               busy_q;
  logic               gnt_q;
  logic               done_q;
  logic               ack0_q;
  logic               ack1_q;
  logic [DW-1:0]      sum_q;
  logic               co_q;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_ci;
  logic [WIDTH-1:0]   add_s;
  logic [NSLICE:0]    slice_c;
  logic               add_co;

  // Shared adder operand select: low halves first, high halves with chained carry second.
  always_comb begin
    add_a  = a_lo_q;
    add_b  = b_lo_q;
    add_ci = cin_q;
`ifdef ADDSCHED_CHAIN_EN
    if (state_q == CALC_HI) begin
      add_a  = a_hi_q;
      add_b  = b_hi_q;
      add_ci = carry_q;
    end
`endif
  end

  assign slice_c[0] = add_ci;
  assign add_co     = slice_c[NSLICE];

  for (genvar i = 0; i < int'(NSLICE); i++) begin : g_slice
    logic [4:0] slice_sum;
    assign slice_sum           = 5'({1'b0, add_a[4*i +: 4]}) + 5'({1'b0, add_b[4*i +: 4]})
                               + 5'(slice_c[i]);
    assign add_s[4*i +: 4]     = slice_sum[3:0];
    assign slice_c[i+1]        = slice_sum[4];
  end

  // Next-state and grant decision.
  always_comb begin
    state_d = state_q;
    grant_c = 1'b0;
    gsel_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_c = 1'b1;
          gsel_c  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          state_d = CALC_LO;
        end
      end
      CALC_LO: begin
`ifdef ADDSCHED_CHAIN_EN
        state_d = wide_q ? CALC_HI : DONE;
`else
        state_d = DONE;
`endif
      end
`ifdef ADDSCHED_CHAIN_EN
      CALC_HI: state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      a_lo_q  <= '0;
      b_lo_q  <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
`ifdef ADDSCHED_CHAIN_EN
      a_hi_q  <= '0;
      b_hi_q  <= '0;
      wide_q  <= 1'b0;
`endif
      busy_q  <= 1'b0;
      gnt_q   <= 1'b0;
      done_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      // gnt is already final by the time DONE is entered
      ack0_q  <= (state_d == DONE) && !gnt_q;
      ack1_q  <= (state_d == DONE) &&  gnt_q;

      if (grant_c) begin
        gnt_q  <= gsel_c;
        last_q <= gsel_c;
        a_lo_q <= gsel_c ? bus.a1[WIDTH-1:0] : bus.a0[WIDTH-1:0];
        b_lo_q <= gsel_c ? bus.b1[WIDTH-1:0] : bus.b0[WIDTH-1:0];
        cin_q  <= gsel_c ? bus.cin1 : bus.cin0;
`ifdef ADDSCHED_CHAIN_EN
        a_hi_q <= gsel_c ? bus.a1[DW-1:WIDTH] : bus.a0[DW-1:WIDTH];
        b_hi_q <= gsel_c ? bus.b1[DW-1:WIDTH] : bus.b0[DW-1:WIDTH];
        wide_q <= gsel_c ? bus.wide1 : bus.wide0;
`endif
      end

      if (state_q == CALC_LO) begin
        sum_q[WIDTH-1:0] <= add_s;
        carry_q          <= add_co;
`ifdef ADDSCHED_CHAIN_EN
        if (!wide_q) begin
          sum_q[DW-1:WIDTH] <= '0;
          co_q              <= add_co;
        end
`else
        sum_q[DW-1:WIDTH] <= '0;
        co_q              <= add_co;
`endif
      end

`ifdef ADDSCHED_CHAIN_EN
      if (state_q == CALC_HI) begin
        sum_q[DW-1:WIDTH] <= add_s;
        co_q              <= add_co;
      end
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;

`ifndef ADDSCHED_CHAIN_EN
  // Narrow-only build: wide selects, upper operand halves and the chain carry have no reader.
  logic unused_wide;
  assign unused_wide = ^{bus.wide0, bus.wide1, bus.a0[DW-1:WIDTH], bus.b0[DW-1:WIDTH],
                         bus.a1[DW-1:WIDTH], bus.b1[DW-1:WIDTH], carry_q};
`endif

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed self-checking bench for adder_scheduler; expectations follow ADDSCHED_CHAIN_EN.
module tb_adder_scheduler;

  localparam int unsigned WIDTH = 16;

`ifdef ADDSCHED_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  adder_scheduler_if #(.WIDTH(WIDTH)) bus ();

  adder_scheduler #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wide0 = 1'b0; bus.wide1 = 1'b0;
    bus.cin0 = 1'b0; bus.cin1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.a0 = 32'h0000_0003; bus.b0 = 32'h0000_0004;
    bus.a1 = 32'h0000_0100; bus.b1 = 32'h0000_0200;
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.gnt, bus.ack0, bus.ack1, bus.co} !== 6'b0 || bus.sum !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b gnt=%b ack0=%b ack1=%b co=%b sum=%h expected all zero",
               bus.busy, bus.done, bus.gnt, bus.ack0, bus.ack1, bus.co, bus.sum);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: busy=%b gnt=%b expected busy=1 gnt=0", bus.busy, bus.gnt);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.ack0 !== 1'b1 || bus.sum !== 32'h0000_0007) begin
      errors++;
      $display("FAIL reset_first_result: done=%b ack0=%b sum=%h expected 1 1 00000007",
               bus.done, bus.ack0, bus.sum);
    end
    tick();
  endtask

  task automatic test_narrow_carry();
    clear_inputs();
    bus.req0 = 1'b1; bus.a0 = 32'h0000_FFFF; bus.b0 = 32'h0000_0001; bus.cin0 = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.gnt !== 1'b0) begin
      errors++;
      $display("FAIL narrow_cycle1: busy=%b done=%b gnt=%b expected 1 0 0", bus.busy, bus.done, bus.gnt);
    end
    bus.req0 = 1'b0; bus.a0 = 32'h1234_5678; bus.b0 = 32'h1111_1111; bus.cin0 = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.sum !== 32'h0 || bus.co !== 1'b1) begin
      errors++;
      $display("FAIL narrow_carry: done=%b ack0=%b ack1=%b sum=%h co=%b expected 1 1 0 00000000 1",
               bus.done, bus.ack0, bus.ack1, bus.sum, bus.co);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ack0 !== 1'b0 || bus.sum !== 32'h0 || bus.co !== 1'b1) begin
      errors++;
      $display("FAIL narrow_after: busy=%b done=%b ack0=%b sum=%h co=%b expected 0 0 0 00000000 1",
               bus.busy, bus.done, bus.ack0, bus.sum, bus.co);
    end
  endtask

  task automatic test_arbitration();
    int          n;
    int          exp_port [3];
    logic [31:0] exp_sum  [3];
    exp_port = '{0, 1, 0};
    exp_sum  = '{32'h0000_2345, 32'h0000_1001, 32'h0000_2345};
    clear_inputs();
    do_reset();
    bus.a0 = 32'h0000_1234; bus.b0 = 32'h0000_1111; bus.cin0 = 1'b0;
    bus.a1 = 32'h0000_0F0F; bus.b1 = 32'h0000_00F1; bus.cin1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        checks++;
        if (bus.ack0 !== (exp_port[n] == 0) || bus.ack1 !== (exp_port[n] == 1) ||
            bus.sum !== exp_sum[n] || bus.co !== 1'b0 || i != 3 * n + 2) begin
          errors++;
          $display("FAIL arb_result%0d: cycle=%0d ack0=%b ack1=%b sum=%h co=%b expected cycle=%0d port=%0d sum=%h co=0",
                   n, i, bus.ack0, bus.ack1, bus.sum, bus.co, 3 * n + 2, exp_port[n], exp_sum[n]);
        end
        n++;
        if (n == 3) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL arb_count: saw %0d dones expected 3", n);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 1'b0) begin
      errors++;
      $display("FAIL arb_idle: busy=%b gnt=%b expected 0 0", bus.busy, bus.gnt);
    end
  endtask

  task automatic test_wide();
    logic [31:0] va   [3];
    logic [31:0] vb   [3];
    logic        vc   [3];
    logic [31:0] esum [3];
    logic        eco  [3];
    int          ecyc;
    int          cyc;
    va = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0001_8000};
    vb = '{32'h0000_0001, 32'h0000_0001, 32'h0002_8000};
    vc = '{1'b0, 1'b0, 1'b1};
    if (CHAIN) begin
      esum = '{32'h0001_0000, 32'h0000_0000, 32'h0004_0001};
      eco  = '{1'b0, 1'b1, 1'b0};
      ecyc = 3;
    end else begin
      esum = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
      eco  = '{1'b1, 1'b1, 1'b1};
      ecyc = 2;
    end
    clear_inputs();
    for (int v = 0; v < 3; v++) begin
      bus.a1 = va[v]; bus.b1 = vb[v]; bus.cin1 = vc[v]; bus.wide1 = 1'b1; bus.req1 = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (i == 1) begin
          bus.a1 = 32'hDEAD_BEEF; bus.b1 = 32'hCAFE_F00D; bus.cin1 = ~vc[v]; bus.wide1 = 1'b0;
        end
        if (bus.done === 1'b1) begin
          cyc = i;
          break;
        end
      end
      bus.req1 = 1'b0;
      checks++;
      if (cyc != ecyc || bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.sum !== esum[v] || bus.co !== eco[v]) begin
        errors++;
        $display("FAIL wide_vec%0d: cycle=%0d ack1=%b ack0=%b sum=%h co=%b expected cycle=%0d ack1=1 sum=%h co=%b",
                 v, cyc, bus.ack1, bus.ack0, bus.sum, bus.co, ecyc, esum[v], eco[v]);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== esum[v]) begin
        errors++;
        $display("FAIL wide_hold%0d: busy=%b done=%b sum=%h expected 0 0 %h",
                 v, bus.busy, bus.done, bus.sum, esum[v]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.req0 = 1'b1; bus.a0 = 32'h0000_0001; bus.b0 = 32'h0000_0001;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.sum === 32'h0) begin
      errors++;
      $display("FAIL midrst_setup: busy=%b sum=%h expected busy=1 and nonzero prior sum", bus.busy, bus.sum);
    end
    resetn = 1'b0;
    bus.req1 = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.ack0, bus.ack1, bus.gnt, bus.co} !== 6'b0 || bus.sum !== 32'h0) begin
      errors++;
      $display("FAIL midrst_abandon: busy=%b done=%b ack0=%b ack1=%b gnt=%b co=%b sum=%h expected all zero",
               bus.busy, bus.done, bus.ack0, bus.ack1, bus.gnt, bus.co, bus.sum);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.ack0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodone: done=%b ack0=%b expected 0 0", bus.done, bus.ack0);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.gnt !== 1'b0) begin
      errors++;
      $display("FAIL midrst_grant: busy=%b gnt=%b expected 1 0", bus.busy, bus.gnt);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.ack0 !== 1'b1 || bus.sum !== 32'h0000_0002 || bus.co !== 1'b0) begin
      errors++;
      $display("FAIL midrst_result: done=%b ack0=%b sum=%h co=%b expected 1 1 00000002 0",
               bus.done, bus.ack0, bus.sum, bus.co);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_narrow_carry();
    test_arbitration();
    test_wide();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Sequencer and two-port round-robin arbiter for one shared WIDTH-bit ripple-carry adder (the team's 16-bit adder built from 4-bit slices). Two requesters each present operands and a carry-in. The block grants one requester, latches its operands, runs the add (one pass, or two chained passes for a 2·WIDTH-bit add when enabled) and returns a registered result with a one-cycle acknowledge. It sits between the lab control logic and the adder datapath.

## Interface
- WIDTH, 16, adder width in bits; must be a multiple of 4.
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, synchronous and active-low.
- req0, req1  in  1  request, per port; held high until that port's ack.
- wide0, wide1  in  1  request a 2·WIDTH-bit add; used only with ADDSCHED_CHAIN_EN.
- cin0, cin1  in  1  carry-in, per port.
- a0, b0, a1, b1  in  2·WIDTH  operands, per port; upper WIDTH bits used only in wide mode.
- busy  out  1  high in every state except IDLE.
- gnt  out  1  index of the port currently or last granted.
- done  out  1  one-cycle result-valid strobe.
- ack0, ack1  out  1  done & (gnt == port index).
- sum  out  2·WIDTH  registered result; held from done until the next done.
- co  out  1  registered carry-out; held the same way.

## Operation
- States: IDLE, CALC_LO, CALC_HI (only with macro), DONE.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant that port.
- IDLE, both requests: grant the port not equal to the last-served pointer `last`. Reset sets last=1, so port 0 wins first.
- On grant:
  - Latch a, b, cin and wide of the granted port.
  - Set gnt and last to the granted index.
  - Go to CALC_LO.
  - Operands may change after the grant edge.
- CALC_LO:
  - Adder input is latched a[W-1:0] + b[W-1:0] + cin.
  - Register sum[W-1:0] and the carry into an internal carry register.
  - If the latched wide is set and the macro is defined, go to CALC_HI. Otherwise clear sum[2W-1:W], set co = carry, go to DONE.
- CALC_HI:
  - Adder input is a[2W-1:W] + b[2W-1:W] + carry register.
  - Register sum[2W-1:W] and set co = carry-out.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle; the matching ack is high in that cycle.
  - Requests are ignored.
  - Next state is IDLE.
- Arithmetic:
  - Narrow: sum = zero-extended (a_lo + b_lo + cin) mod 2^W; co = bit W of the add.
  - Wide: sum = (a + b + cin) mod 2^(2W); co = bit 2W of the add.
- Request held after its ack:
  - Treated as a new request in IDLE.
  - With both ports held, grants alternate 0,1,0,1.
- Reset (any state):
  - Next state is IDLE and any in-flight operation is abandoned with no done.
  - busy=0, done=0, gnt=0, sum=0, co=0, ack0=ack1=0, last=1, carry register=0.

## Timing
- Cycle 0: request sampled in IDLE; grant edge at the end of cycle 0.
- Narrow latency: done high in cycle 2.
- Wide latency: done high in cycle 3.
- Throughput: one narrow op per 3 cycles, one wide op per 4 cycles (DONE always returns to IDLE).
- busy rises in cycle 1 and falls in the cycle after done.
- gnt updates at the grant edge and stays stable until the next grant.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A request arriving during DONE is first sampled in the following IDLE cycle.

## Configuration
- ADDSCHED_CHAIN_EN defined:
  - CALC_HI is present.
  - wide0/wide1 select the two-pass 2·WIDTH-bit add with the carry chained between passes.
- Not defined:
  - CALC_HI and the carry-chain path are removed.
  - wide0/wide1 and the operand upper halves are ignored.
  - Every op is narrow; sum[2W-1:W] is always 0.

## Test plan
- Reset: hold resetn=0 for 2 cycles with req0=req1=1 -> busy=0, done=0, gnt=0, sum=0, co=0; port 0 is granted first after release.
- Narrow carry: req0, a0=0x0000FFFF, b0=0x00000001, cin0=0 -> done and ack0 in cycle 2, sum=0x00000000, co=1.
- Arbitration: req0 (0x1234+0x1111, cin0=0) and req1 (0x0F0F+0x00F1, cin1=1) both held -> ack0 with sum=0x00002345, then ack1 with sum=0x00001001, then ack0 again.
- Wide with macro: req1, wide1=1, a1=0x0000FFFF, b1=0x00000001 -> done in cycle 3, sum=0x00010000, co=0. Then a1=0xFFFFFFFF, b1=1 -> sum=0, co=1.
- Wide without macro: a1=0xFFFFFFFF, b1=1, wide1=1 -> done in cycle 2, sum=0x00000000, co=1.
- Reset mid-op: resetn=0 during CALC_LO -> no done or ack; next cycle state is IDLE with sum=0. After release with both ports requesting, port 0 is granted first.
